// File: rtl/aes_pkg.sv
// Shared constants for the AES datapath and its pipeline registers.
package aes_pkg;

   // AES state and key widths.
   localparam int unsigned AES_BLOCK_W    = 128;
   localparam int unsigned AES_KEY_W      = 128;

   // Default number of register stages between round stages.
   localparam int unsigned PIPE_DEPTH_DEF = 2;

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
// Optional macro PIPE_REG_CHAIN_DATA_RST_EN: rst and flush also clear the data register.
module pipe_reg_stage
   import aes_pkg::*;
#(
   parameter int unsigned WIDTH = AES_BLOCK_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             adv,
   input  logic             load,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   // Valid bit follows its source whenever the stage advances; rst/flush empty it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q <= 1'b0;
      end else if (adv) begin
         valid_q <= src_valid;
      end
   end

`ifdef PIPE_REG_CHAIN_DATA_RST_EN
   // Data captured only on a real load; cleared on rst/flush so no state lingers.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= src_data;
      end
   end
`else
   // Data captured only on a real load; bubbles leave it untouched.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= src_data;
      end
   end
`endif

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage WIDTH-bit register pipeline with valid/ready handshake,
// bubble collapsing and flush. Ready is combinational through the chain; data
// and valid are fully registered, so there is no path from in_* to out_*.
// Optional macro PIPE_REG_CHAIN_DATA_RST_EN: rst and flush also zero all data.
module pipe_reg_chain
   import aes_pkg::*;
#(
   parameter  int unsigned WIDTH = AES_BLOCK_W,
   parameter  int unsigned DEPTH = PIPE_DEPTH_DEF,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] src_valid;
   logic [WIDTH-1:0] src_data [DEPTH];
   logic [WIDTH-1:0] d        [DEPTH];
   logic             tail_full;

   // Stage i advances unless it and every stage downstream of it is full
   // while the sink stalls; unrolled this way to avoid a self-referencing chain.
   always_comb begin
      adv       = '0;
      tail_full = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tail_full = 1'b1;
         for (int j = i; j < DEPTH; j++) begin
            tail_full = tail_full & v[j];
         end
         adv[i] = out_ready | ~tail_full;
      end
   end

   // Occupancy is the population count of the registered valid bits.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + CNT_W'(v[i]);
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign src_valid[i] = in_valid;
         assign src_data[i]  = in_data;
      end else begin : g_body
         assign src_valid[i] = v[i-1];
         assign src_data[i]  = d[i-1];
      end

      // No transfers at all during rst or flush.
      assign load[i] = adv[i] & src_valid[i] & ~flush & ~rst;

      pipe_reg_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .adv      (adv[i]),
         .load     (load[i]),
         .src_valid(src_valid[i]),
         .src_data (src_data[i]),
         .valid    (v[i]),
         .data     (d[i])
      );
   end

   assign in_ready  = adv[0] & ~flush & ~rst;
   assign out_valid = v[DEPTH-1] & ~flush & ~rst;
   assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=2 and a DEPTH=4 instance driven with the same
// stimulus, each compared every cycle against a word-list reference model, plus a
// directed vector table (DEPTH=2) and a bubble-collapse sequence (DEPTH=4).
module tb_pipe_reg_chain;

   localparam int unsigned W = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_data;

   logic         ir2, ov2, ir4, ov4;
   logic [W-1:0] od2, od4;
   logic [1:0]   occ2;
   logic [2:0]   occ4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(W), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2)
   );

   pipe_reg_chain #(.WIDTH(W), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .occupancy(occ4)
   );

   // Reference model: per instance an oldest-first list of words, each with the
   // stage index it currently sits in.
   int           m_cnt [2];
   int           m_pos [2][4];
   logic [W-1:0] m_dat [2][4];

   function automatic int depth_of(input int m);
      return (m == 0) ? 2 : 4;
   endfunction

   // Accepts unless every stage is occupied and the sink stalls.
   function automatic bit model_ready(input int m);
      return !rst && !flush && !(m_cnt[m] == depth_of(m) && !out_ready);
   endfunction

   function automatic bit model_out_valid(input int m);
      return !rst && !flush && m_cnt[m] > 0 && m_pos[m][0] == depth_of(m) - 1;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check(input int m, input logic a_ir, input logic a_ov,
                              input logic [W-1:0] a_od, input int a_occ);
      int d;
      d = depth_of(m);
      chk($sformatf("d%0d in_ready", d), W'(a_ir), W'(model_ready(m)));
      chk($sformatf("d%0d out_valid", d), W'(a_ov), W'(model_out_valid(m)));
      chk($sformatf("d%0d occupancy", d), W'(a_occ), W'(m_cnt[m]));
      if (model_out_valid(m)) chk($sformatf("d%0d out_data", d), a_od, m_dat[m][0]);
   endtask

   // Each word moves one stage per edge, never past the word ahead of it; the
   // head leaves from the last stage when the sink is ready.
   function automatic void model_update(input int m);
      int           d, nc, lim, p;
      int           np [4];
      logic [W-1:0] nd [4];
      bit           acc;
      if (rst || flush) begin
         m_cnt[m] = 0;
         return;
      end
      d   = depth_of(m);
      acc = in_valid && model_ready(m);
      nc  = 0;
      lim = d - 1;
      for (int k = 0; k < m_cnt[m]; k++) begin
         if (k == 0 && m_pos[m][0] == d - 1 && out_ready) continue;
         p = m_pos[m][k] + 1;
         if (p > lim) p = lim;
         np[nc] = p;
         nd[nc] = m_dat[m][k];
         nc++;
         lim = p - 1;
      end
      if (acc) begin
         np[nc] = 0;
         nd[nc] = in_data;
         nc++;
      end
      for (int k = 0; k < nc; k++) begin
         m_pos[m][k] = np[k];
         m_dat[m][k] = nd[k];
      end
      m_cnt[m] = nc;
   endfunction

   // Drive inputs away from the active edge, then check both instances.
   task automatic apply(input logic iv, input logic [W-1:0] din, input logic ordy,
                        input logic fl, input logic r);
      @(negedge clk);
      in_valid  = iv;
      in_data   = din;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #1;
      model_check(0, ir2, ov2, od2, int'(occ2));
      model_check(1, ir4, ov4, od4, int'(occ4));
   endtask

   task automatic commit();
      @(posedge clk);
      model_update(0);
      model_update(1);
   endtask

   typedef struct {
      logic         iv;
      logic [W-1:0] din;
      logic         ordy;
      logic         fl;
      logic         r;
      logic         e_ir;
      logic         e_ov;
      logic [W-1:0] e_od;
      int           e_occ;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [W-1:0] din, input logic ordy,
                               input logic fl, input logic r, input logic e_ir,
                               input logic e_ov, input logic [W-1:0] e_od, input int e_occ);
      vec_t t;
      t = '{iv, din, ordy, fl, r, e_ir, e_ov, e_od, e_occ};
      return t;
   endfunction

   vec_t         tbl [18];
   logic [W-1:0] words [4];
   bit           hold;
   bit           acc;
   logic         r_iv, r_or, r_fl, r_rst;
   logic [W-1:0] r_din;

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_data   = W'(8'h55);
      m_cnt[0]  = 0;
      m_cnt[1]  = 0;
      @(posedge clk);

      // iv, din, out_ready, flush, rst | in_ready, out_valid, out_data, occupancy (DEPTH=2)
      tbl[0]  = mk(1, W'(8'h55), 0, 0, 1, 0, 0, '0, 0);
      tbl[1]  = mk(1, W'(8'h01), 1, 0, 0, 1, 0, '0, 0);
      tbl[2]  = mk(1, W'(8'h02), 1, 0, 0, 1, 0, '0, 1);
      tbl[3]  = mk(1, W'(8'h03), 1, 0, 0, 1, 1, W'(8'h01), 2);
      tbl[4]  = mk(0, '0,        1, 0, 0, 1, 1, W'(8'h02), 2);
      tbl[5]  = mk(0, '0,        1, 0, 0, 1, 1, W'(8'h03), 1);
      tbl[6]  = mk(1, W'(8'hAA), 0, 0, 0, 1, 0, '0, 0);
      tbl[7]  = mk(1, W'(8'hBB), 0, 0, 0, 1, 0, '0, 1);
      tbl[8]  = mk(1, W'(8'hCC), 0, 0, 0, 0, 1, W'(8'hAA), 2);
      tbl[9]  = mk(1, W'(8'hCC), 0, 0, 0, 0, 1, W'(8'hAA), 2);
      tbl[10] = mk(1, W'(8'hCC), 1, 0, 0, 1, 1, W'(8'hAA), 2);
      tbl[11] = mk(0, '0,        1, 0, 0, 1, 1, W'(8'hBB), 2);
      tbl[12] = mk(1, W'(8'hEE), 0, 0, 0, 1, 1, W'(8'hCC), 1);
      tbl[13] = mk(1, W'(8'hFF), 1, 1, 0, 0, 0, '0, 2);
      tbl[14] = mk(1, W'(8'hDD), 0, 0, 0, 1, 0, '0, 0);
      tbl[15] = mk(0, '0,        0, 0, 0, 1, 0, '0, 1);
      tbl[16] = mk(0, '0,        1, 0, 0, 1, 1, W'(8'hDD), 1);
      tbl[17] = mk(0, '0,        1, 0, 0, 1, 0, '0, 0);

      for (int k = 0; k < 18; k++) begin
         apply(tbl[k].iv, tbl[k].din, tbl[k].ordy, tbl[k].fl, tbl[k].r);
         chk($sformatf("vec%0d in_ready", k), W'(ir2), W'(tbl[k].e_ir));
         chk($sformatf("vec%0d out_valid", k), W'(ov2), W'(tbl[k].e_ov));
         chk($sformatf("vec%0d occupancy", k), W'(occ2), W'(tbl[k].e_occ));
         if (tbl[k].e_ov) chk($sformatf("vec%0d out_data", k), od2, tbl[k].e_od);
`ifdef PIPE_REG_CHAIN_DATA_RST_EN
         if (k == 0) chk("reset out_data", od2, '0);
`endif
         commit();
      end

      // Bubble collapse on DEPTH=4: a lone word walks to the last stage while stalled.
      words[0] = {4{32'h1111_0001}};
      words[1] = {4{32'h2222_0002}};
      words[2] = {4{32'h3333_0003}};
      words[3] = {4{32'h4444_0004}};
      apply(0, '0, 0, 0, 1);
      commit();
      apply(1, words[0], 0, 0, 0);
      chk("bubble first in_ready", W'(ir4), W'(1'b1));
      commit();
      repeat (3) begin
         apply(0, '0, 0, 0, 0);
         commit();
      end
      for (int k = 1; k < 4; k++) begin
         apply(1, words[k], 0, 0, 0);
         chk($sformatf("bubble fill%0d in_ready", k), W'(ir4), W'(1'b1));
         chk($sformatf("bubble fill%0d occupancy", k), W'(occ4), W'(k));
         chk($sformatf("bubble fill%0d out_data", k), od4, words[0]);
         commit();
      end
      apply(1, {4{32'h5555_0005}}, 0, 0, 0);
      chk("bubble full in_ready", W'(ir4), W'(1'b0));
      chk("bubble full occupancy", W'(occ4), W'(4));
      commit();
      for (int k = 0; k < 4; k++) begin
         apply(0, '0, 1, 0, 0);
         chk($sformatf("bubble drain%0d out_valid", k), W'(ov4), W'(1'b1));
         chk($sformatf("bubble drain%0d out_data", k), od4, words[k]);
         commit();
      end
      apply(0, '0, 1, 0, 0);
      chk("bubble empty out_valid", W'(ov4), W'(1'b0));
      chk("bubble empty occupancy", W'(occ4), W'(0));
      commit();

      // Randomized traffic; an offered word is held until the DEPTH=2 instance takes it.
      hold = 1'b0;
      r_iv = 1'b0;
      r_din = '0;
      for (int c = 0; c < 1500; c++) begin
         if (!hold) begin
            r_iv  = ($urandom_range(99) < 70);
            r_din = {$urandom, $urandom, $urandom, $urandom};
         end
         r_or  = ($urandom_range(99) < 60);
         r_fl  = ($urandom_range(99) < 2);
         r_rst = ($urandom_range(99) < 1);
         apply(r_iv, r_din, r_or, r_fl, r_rst);
         acc  = r_iv && model_ready(0);
         hold = r_iv && !acc && !r_fl && !r_rst;
         commit();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
